// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder for the MEM-stage load/store port.
// Accepts one access in IDLE, holds stall_o while it is in flight, then acks for one cycle.
module dmem_responder #(
    parameter int DEPTH   = 32,
    parameter int LATENCY = 3
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        MemRead_i,
    input  logic        MemWrite_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] w_data_i,
    output logic [31:0] r_data_o,
    output logic        ack_o,
    output logic        err_o,
    output logic        stall_o
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = (LATENCY > 2) ? $clog2(LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = (LATENCY > 1) ? CNT_W'(LATENCY - 2) : '0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t             state_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic               write_reg;
    logic [IDX_W-1:0]   idx_reg;
    logic [31:0]        wdata_reg;
    logic [31:0]        r_data_reg;
    logic               ack_reg;
    logic               err_reg;

    logic [31:0]        mem [DEPTH];
    logic [DEPTH-1:0]   word_we;

    logic               req;
    logic               req_err;
    logic               commit_now;
    logic               commit_write;
    logic [IDX_W-1:0]   commit_idx;
    logic [31:0]        commit_data;
    logic [31:0]        rd_word;

    assign req     = MemRead_i | MemWrite_i;
    // Out of range means any address bit above the word index is set: no wrap-around.
    assign req_err = (MemRead_i & MemWrite_i) | (|addr_i[1:0]) | (|addr_i[31:IDX_W+2]);

    // The access commits on the edge entering RESP; with LATENCY=1 that edge is the
    // request edge itself, so the live inputs are used instead of the latched copies.
    always_comb begin
        commit_now   = 1'b0;
        commit_write = write_reg;
        commit_idx   = idx_reg;
        commit_data  = wdata_reg;
        if (state_reg == IDLE) begin
            commit_now   = req & ~req_err & (LATENCY == 1);
            commit_write = MemWrite_i;
            commit_idx   = addr_i[IDX_W+1:2];
            commit_data  = w_data_i;
        end else if (state_reg == BUSY) begin
            commit_now   = (cnt_reg == '0);
        end
    end

    assign rd_word = mem[commit_idx];

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_word_we
        assign word_we[gi] = commit_now & commit_write & (commit_idx == IDX_W'(gi));
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (word_we[i]) begin
                    mem[i] <= commit_data;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_reg  <= IDLE;
            cnt_reg    <= '0;
            write_reg  <= 1'b0;
            idx_reg    <= '0;
            wdata_reg  <= '0;
            r_data_reg <= '0;
            ack_reg    <= 1'b0;
            err_reg    <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (req) begin
                        write_reg <= MemWrite_i;
                        idx_reg   <= addr_i[IDX_W+1:2];
                        wdata_reg <= w_data_i;
                        if (req_err) begin
                            state_reg  <= RESP;
                            ack_reg    <= 1'b1;
                            err_reg    <= 1'b1;
                            r_data_reg <= '0;
                        end else if (LATENCY == 1) begin
                            state_reg <= RESP;
                            ack_reg   <= 1'b1;
                            err_reg   <= 1'b0;
                            if (!MemWrite_i) begin
                                r_data_reg <= rd_word;
                            end
                        end else begin
                            state_reg <= BUSY;
                            cnt_reg   <= CNT_INIT;
                        end
                    end
                end
                BUSY: begin
                    if (cnt_reg == '0) begin
                        state_reg <= RESP;
                        ack_reg   <= 1'b1;
                        err_reg   <= 1'b0;
                        if (!write_reg) begin
                            r_data_reg <= rd_word;
                        end
                    end else begin
                        cnt_reg <= cnt_reg - CNT_W'(1);
                    end
                end
                RESP: begin
                    state_reg <= IDLE;
                    ack_reg   <= 1'b0;
                    err_reg   <= 1'b0;
                end
                default: begin
                    state_reg <= IDLE;
                    ack_reg   <= 1'b0;
                    err_reg   <= 1'b0;
                end
            endcase
        end
    end

    assign r_data_o = r_data_reg;
    assign ack_o    = ack_reg;
    assign err_o    = err_reg;
    // Low in RESP so the pipeline advances at the end of the ack cycle.
    assign stall_o  = ((state_reg == IDLE) & req) | (state_reg == BUSY);

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: a LATENCY=3 instance carries the main traffic,
// a LATENCY=1 instance covers the single-cycle path.
module tb_dmem_responder;

    localparam int DEPTH   = 32;
    localparam int LATENCY = 3;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        mem_read, mem_write;
    logic [31:0] addr, wdata;
    logic [31:0] rdata;
    logic        ack, err, stall;

    logic        mem_read1;
    logic [31:0] addr1;
    logic [31:0] rdata1;
    logic        ack1, err1, stall1;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc_cnt  = 0;
    int          prev_ack = 0;
    bit          have_prev = 0;
    bit          spacing_en = 0;
    int          n_acks   = 0;

    exp_t        sb[$];
    logic [31:0] model [DEPTH];
    logic [31:0] last_rdata = '0;

    dmem_responder #(.DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
        .clk_i(clk), .rst_i(rst_n),
        .MemRead_i(mem_read), .MemWrite_i(mem_write),
        .addr_i(addr), .w_data_i(wdata),
        .r_data_o(rdata), .ack_o(ack), .err_o(err), .stall_o(stall)
    );

    dmem_responder #(.DEPTH(DEPTH), .LATENCY(1)) dut1 (
        .clk_i(clk), .rst_i(rst_n),
        .MemRead_i(mem_read1), .MemWrite_i(1'b0),
        .addr_i(addr1), .w_data_i(32'h0),
        .r_data_o(rdata1), .ack_o(ack1), .err_o(err1), .stall_o(stall1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc_cnt++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Monitor: every ack pops one expected result from the scoreboard.
    initial forever begin
        @(negedge clk);
        if (ack === 1'b1) begin
            n_acks++;
            if (sb.size() == 0) begin
                check("unexpected_ack", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                $display("ack %0d at cycle %0d: err=%0d r_data=%h", n_acks, cyc_cnt, err, rdata);
                check("err_o", {31'd0, err}, {31'd0, e.err});
                check("r_data_o", rdata, e.rdata);
            end
            if (spacing_en && have_prev) begin
                check("ack_spacing", cyc_cnt - prev_ack, LATENCY + 1);
            end
            prev_ack  = cyc_cnt;
            have_prev = 1'b1;
        end
    end

    // Issues one access starting just after a rising edge; returns just after the
    // edge that ends the ack cycle, so a following call is back-to-back.
    task automatic access(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
        exp_t e;
        int   exp_lat;
        int   cyc;
        bit   got;
        bit   legal;
        legal = !(rd && wr) && (a[1:0] == 2'b00) && (a[31:2] < DEPTH);
        if (!legal) begin
            e.err = 1'b1;
            e.rdata = '0;
            exp_lat = 1;
        end else begin
            e.err = 1'b0;
            exp_lat = LATENCY;
            if (wr) begin
                model[a[6:2]] = d;
                e.rdata = last_rdata;
            end else begin
                e.rdata = model[a[6:2]];
            end
        end
        last_rdata = e.rdata;
        sb.push_back(e);
        mem_read  = rd;
        mem_write = wr;
        addr      = a;
        wdata     = d;
        cyc = 0;
        got = 1'b0;
        while (!got && cyc <= 20) begin
            @(negedge clk);
            if (ack === 1'b1) begin
                got = 1'b1;
                check("ack_cycle", cyc, exp_lat);
                check("stall_in_ack", {31'd0, stall}, 32'd0);
            end else begin
                check("stall_busy", {31'd0, stall}, 32'd1);
            end
            @(posedge clk);
            #1;
            if (cyc == 0) begin
                mem_read  = 1'b0;
                mem_write = 1'b0;
                addr      = 32'hFFFF_FFFF;
                wdata     = 32'hCAFE_F00D;
            end
            cyc++;
        end
        if (!got) check("ack_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
        rst_n = 1'b0;
        mem_read = 0; mem_write = 0; addr = 0; wdata = 0;
        mem_read1 = 0; addr1 = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ack", {31'd0, ack}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_stall", {31'd0, stall}, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // LATENCY=1 instance: read 0x04 after reset
        mem_read1 = 1'b1;
        addr1 = 32'h04;
        @(negedge clk);
        check("l1_stall_req", {31'd0, stall1}, 32'd1);
        check("l1_ack_req", {31'd0, ack1}, 32'd0);
        @(posedge clk);
        #1;
        mem_read1 = 1'b0;
        addr1 = 32'h0;
        @(negedge clk);
        check("l1_ack", {31'd0, ack1}, 32'd1);
        check("l1_err", {31'd0, err1}, 32'd0);
        check("l1_rdata", rdata1, 32'd0);
        check("l1_stall_ack", {31'd0, stall1}, 32'd0);
        @(negedge clk);
        check("l1_ack_drop", {31'd0, ack1}, 32'd0);
        @(posedge clk);
        #1;

        // Write then read the same word
        access(1'b0, 1'b1, 32'h08, 32'hDEAD_BEEF);
        access(1'b1, 1'b0, 32'h08, 32'h0);

        // Illegal requests: misaligned, out of range, both ops at once
        access(1'b1, 1'b0, 32'h06, 32'h0);
        access(1'b0, 1'b1, 32'h80, 32'h5555_5555);
        access(1'b1, 1'b1, 32'h10, 32'h1234);
        access(1'b1, 1'b0, 32'h10, 32'h0);
        for (int i = 0; i < DEPTH; i++) begin
            access(1'b1, 1'b0, 32'(i * 4), 32'h0);
        end

        // Reset while a write is in BUSY
        sb.push_back('{err: 1'b0, rdata: 32'h0});
        mem_write = 1'b1;
        addr = 32'h0C;
        wdata = 32'hA5A5_A5A5;
        @(posedge clk);
        #1;
        mem_write = 1'b0;
        check("busy_stall", {31'd0, stall}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst_busy_ack", {31'd0, ack}, 32'd0);
        check("rst_busy_err", {31'd0, err}, 32'd0);
        check("rst_busy_stall", {31'd0, stall}, 32'd0);
        void'(sb.pop_back());
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
        last_rdata = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        access(1'b1, 1'b0, 32'h0C, 32'h0);

        // Back-to-back writes then reads
        have_prev  = 1'b0;
        spacing_en = 1'b1;
        access(1'b0, 1'b1, 32'h00, 32'd1);
        access(1'b0, 1'b1, 32'h04, 32'd2);
        access(1'b0, 1'b1, 32'h08, 32'd3);
        access(1'b1, 1'b0, 32'h00, 32'h0);
        access(1'b1, 1'b0, 32'h04, 32'h0);
        access(1'b1, 1'b0, 32'h08, 32'h0);
        spacing_en = 1'b0;

        repeat (2) @(posedge clk);
        check("sb_drained", sb.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
